memory_port_arbiter: RTL and testbench

//  Shares one port of a dual-port block memory between NUM_REQ requesters.
//  - Round-robin arbitration, one access per cycle, valid/ready request handshake.
//  - The memory has a 1-cycle registered read latency.
//  - After reset, optionally sequences a fill pass that writes INIT_VALUE to every

---
 rtl/memory_port_arbiter_pkg.sv | 19 +
 rtl/memory_port_arbiter_rr_arbiter.sv | 35 +++
 rtl/memory_port_arbiter.sv | 98 +++++++++
 tb/tb_memory_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state codes and a
// width helper for the round-robin pointer.
package memory_port_arbiter_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching circularly.
module rr_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    int j;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters with round-robin grant,
// 1-cycle read responses and an optional post-reset fill pass.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ       = 4,
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDRESS_WIDTH = 11,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_wen,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             mem_we,
    output logic [ADDRESS_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_din,
    input  logic [DATA_WIDTH-1:0]            mem_dout,
    output logic                             init_done
);

    localparam int                       PW        = clog2(NUM_REQ);
    localparam logic [0:0]               ST_RESET  = INIT_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    logic [0:0]               state;
    logic [ADDRESS_WIDTH-1:0] fill_cnt;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            next_ptr;
    logic [NUM_REQ-1:0]       rd_tag;
    logic [NUM_REQ-1:0]       grant;
    logic [PW-1:0]            grant_idx;
    logic                     run;
    logic                     any_grant;
    logic                     filling;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Outputs are forced to their reset values while reset is held, so a
    // mid-operation reset drops in-flight responses in the same cycle.
    assign run        = (state == ST_RUN) && !reset;
    assign filling    = (state == ST_INIT) && !reset;
    assign any_grant  = run && (|req_valid);
    assign req_ready  = run ? grant : '0;
    assign init_done  = run;
    assign resp_valid = reset ? '0 : rd_tag;
    assign resp_data  = mem_dout;
    assign next_ptr   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (filling) begin
            mem_we   = 1'b1;
            mem_addr = fill_cnt;
            mem_din  = INIT_VALUE;
        end else if (any_grant) begin
            mem_we   = req_wen[grant_idx];
            mem_addr = req_addr[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            mem_din  = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_RESET;
            fill_cnt <= '0;
            rr_ptr   <= '0;
            rd_tag   <= '0;
        end else begin
            rd_tag <= (any_grant && !req_wen[grant_idx]) ? grant : '0;
            if (state == ST_INIT) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == LAST_ADDR) begin
                    state <= ST_RUN;
                end
            end else if (any_grant) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed scenarios plus random
// traffic checked against a queue/array reference model.
module tb_memory_port_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INIT = 16'hA5A5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [N-1:0]    req_valid, req_ready, req_wen, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_data, mem_din, mem_dout;
    logic [AW-1:0]   mem_addr;
    logic            mem_we, init_done;

    logic [N-1:0]    req_valid2, req_ready2, req_wen2, resp_valid2;
    logic [N*AW-1:0] req_addr2;
    logic [N*DW-1:0] req_wdata2;
    logic [DW-1:0]   resp_data2, mem_din2, mem_dout2;
    logic [AW-1:0]   mem_addr2;
    logic            mem_we2, init_done2;

    memory_port_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .init_done(init_done)
    );

    memory_port_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .INIT_ON_RESET(1'b0), .INIT_VALUE(INIT)
    ) u_noinit (
        .clock(clock), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_wen(req_wen2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_data(resp_data2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_dout(mem_dout2), .init_done(init_done2)
    );

    assign req_valid2 = 4'b1000;
    assign req_wen2   = 4'b0000;
    assign req_addr2  = 16'h5000;
    assign req_wdata2 = '0;
    assign mem_dout2  = '0;

    // Memory with registered 1-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            cyc;
    } resp_t;

    resp_t         q[$];
    resp_t         mon_r;
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_ptr, m_fill;
    bit            m_run;
    bit            noinit_checked;
    logic [N-1:0]  obs_ready;

    bit            p_valid [N];
    bit            p_wen   [N];
    logic [AW-1:0] p_addr  [N];
    logic [DW-1:0] p_wdata [N];
    bit            granted [N];
    logic [N-1:0]  t3_seen [5];

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int i, input bit wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        p_valid[i] = 1'b1;
        p_wen[i]   = wen;
        p_addr[i]  = addr;
        p_wdata[i] = data;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = p_valid[i];
            req_wen[i]             = p_wen[i];
            req_addr[i*AW +: AW]   = p_addr[i];
            req_wdata[i*DW +: DW]  = p_wdata[i];
        end
    endtask

    // Reference model evaluated at the falling edge, once per cycle.
    task automatic evaluate();
        int win;
        int j;
        win = -1;
        obs_ready = req_ready;
        for (int i = 0; i < N; i++) granted[i] = 1'b0;
        if (reset) begin
            chk("reset_ready", req_ready, 0);
            chk("reset_we", mem_we, 0);
            chk("reset_init_done", init_done, 0);
            chk("reset_ready_noinit", req_ready2, 0);
            chk("reset_init_done_noinit", init_done2, 0);
            m_run = 1'b0;
            m_fill = 0;
            m_ptr = 0;
            for (int a = 0; a < DEPTH; a++) ref_mem[a] = INIT;
            return;
        end
        if (!noinit_checked) begin
            chk("noinit_init_done", init_done2, 1);
            chk("noinit_first_grant", req_ready2, 4'b1000);
            chk("noinit_addr", mem_addr2, 5);
            chk("noinit_we", mem_we2, 0);
            noinit_checked = 1'b1;
        end
        if (!m_run) begin
            chk("fill_we", mem_we, 1);
            chk("fill_addr", mem_addr, m_fill);
            chk("fill_din", mem_din, INIT);
            chk("fill_ready", req_ready, 0);
            chk("fill_init_done", init_done, 0);
            m_fill++;
            if (m_fill == DEPTH) m_run = 1'b1;
            return;
        end
        chk("run_init_done", init_done, 1);
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (win < 0 && p_valid[j]) win = j;
        end
        chk("grant", req_ready, (win < 0) ? 0 : (1 << win));
        if (win < 0) begin
            chk("idle_we", mem_we, 0);
        end else begin
            chk("mem_we", mem_we, p_wen[win]);
            chk("mem_addr", mem_addr, p_addr[win]);
            if (p_wen[win]) begin
                chk("mem_din", mem_din, p_wdata[win]);
                ref_mem[p_addr[win]] = p_wdata[win];
            end else begin
                q.push_back(resp_t'{win, ref_mem[p_addr[win]], cyc + 1});
            end
            m_ptr = (win + 1) % N;
            granted[win] = 1'b1;
        end
    endtask

    task automatic tick();
        pack();
        @(negedge clock);
        evaluate();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (granted[i]) p_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Response monitor: independent of stimulus, checks every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                mon_r = q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL lost_resp: got none expected req %0d data %h at cycle %0d", mon_r.idx, mon_r.data, mon_r.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                mon_r = q.pop_front();
                chk("resp_valid", resp_valid, 1 << mon_r.idx);
                chk("resp_data", resp_data, mon_r.data);
            end else begin
                chk("resp_idle", resp_valid, 0);
            end
        end
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'hDEAD;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0; p_wen[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; granted[i] = 1'b0;
        end
        noinit_checked = 1'b0;
        pack();
        @(posedge clock);
        #1;
        idle(3);
        reset = 1'b0;

        // fill pass, then read of addr 7
        idle(DEPTH);
        issue(1, 1'b0, 4'd7, '0);
        idle(2);

        // write then immediate read of the same address
        issue(0, 1'b1, 4'd3, 16'h1234);
        tick();
        issue(0, 1'b0, 4'd3, '0);
        idle(2);

        // single requester back-to-back reads
        for (int k = 0; k < 3; k++) begin
            issue(2, 1'b0, AW'(k + 3), '0);
            tick();
        end
        idle(2);

        // reset while a read is in flight
        issue(1, 1'b0, 4'd9, '0);
        tick();
        reset = 1'b1;
        q.delete();
        tick();
        reset = 1'b0;
        idle(DEPTH);

        // all requesters continuously valid from rr_ptr=0
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) if (!p_valid[i]) issue(i, 1'b0, AW'($urandom_range(DEPTH - 1)), '0);
            tick();
            t3_seen[k] = obs_ready;
        end
        for (int k = 0; k < 5; k++) chk("rr_sequence", t3_seen[k], 1 << (k % N));
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        idle(2);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (p_valid[i]) begin
                    if ($urandom_range(15) == 0) p_valid[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    issue(i, $urandom_range(2) == 0, AW'($urandom_range(DEPTH - 1)), DW'($urandom));
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        idle(3);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
